xram_stream_packer: RTL

//  Upstream feeder of the convolution image RAM (XRAM). Accepts a serial stream of INTWIDTH-bit

---
 rtl/xram_stream_packer_pkg.sv | 21 ++
 rtl/xram_stream_packer_lanes.sv | 64 ++++++
 rtl/xram_stream_packer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/xram_stream_packer_pkg.sv
// Shared configuration for the XRAM stream packer slice.
// Holds the default geometry (pixel width, lanes per write word, read-row
// width, address and length widths) and the packer state encoding.
package xram_stream_packer_pkg;

  localparam int unsigned DEF_INTWIDTH = 16;
  localparam int unsigned DEF_CORE_N   = 4;
  localparam int unsigned DEF_KSIZE    = 16;
  localparam int unsigned DEF_VAW      = 10;
  localparam int unsigned DEF_LENW     = 16;
  // Write words per XRAM read row; fixed by the XRAM bank decode.
  localparam int unsigned DEF_ITERA    = DEF_KSIZE / DEF_CORE_N;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/xram_stream_packer_lanes.sv
// xram_lane_packer: lane assembly for the XRAM write word.
// Decodes the lane write enable from the lane index, accumulates pixels into
// a staging word and transfers it to the output word register when the word
// closes. Lanes never written since the last close stay zero. A pad request
// loads an all-zero word.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clr       discard the partially assembled word
//   beat      a pixel is accepted this cycle
//   close     the accepted pixel completes the word
//   pad       load an all-zero output word
//   lane      lane index for the accepted pixel
//   data      accepted pixel
//   word      registered packed output word, lane 0 in the LSBs
module xram_lane_packer #(
  parameter int unsigned INTWIDTH = 16,
  parameter int unsigned CORE_N   = 4,
  parameter int unsigned LANEW    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       beat,
  input  logic                       close,
  input  logic                       pad,
  input  logic [LANEW-1:0]           lane,
  input  logic [INTWIDTH-1:0]        data,
  output logic [INTWIDTH*CORE_N-1:0] word
);

  logic [INTWIDTH*CORE_N-1:0] acc;
  logic [INTWIDTH*CORE_N-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    for (int unsigned i = 0; i < CORE_N; i++) begin
      if (beat && (lane == LANEW'(i))) begin
        acc_next[i*INTWIDTH +: INTWIDTH] = data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      word <= '0;
    end else begin
      // The closing pixel bypasses the staging register so the word is
      // presented one cycle after its last beat.
      if (clr || (beat && close)) begin
        acc <= '0;
      end else if (beat) begin
        acc <= acc_next;
      end

      if (beat && close) begin
        word <= acc_next;
      end else if (pad) begin
        word <= '0;
      end
    end
  end

endmodule

// File: rtl/xram_stream_packer.sv
// xram_stream_packer: packs a serial pixel stream into XRAM write words.
// Accepts INTWIDTH-bit pixels on a valid/ready handshake, packs CORE_N per
// word and writes them at incrementing word addresses from base_addr. The
// final read row is zero-padded to an ITERA-word boundary, then wr_finish
// pulses once.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        transfer request, sampled only when idle
//   base_addr    first word address
//   len          number of pixels (0 finishes immediately)
//   abort        synchronous cancel
//   s_data/s_valid/s_ready  pixel stream
//   X_wr/X_din/X_din_valid  XRAM write port
//   wr_finish    one-cycle completion pulse
//   busy         not idle
module xram_stream_packer
  import xram_stream_packer_pkg::*;
#(
  parameter int unsigned INTWIDTH = DEF_INTWIDTH,
  parameter int unsigned CORE_N   = DEF_CORE_N,
  parameter int unsigned KSIZE    = DEF_KSIZE,
  parameter int unsigned VAW      = DEF_VAW,
  parameter int unsigned LENW     = DEF_LENW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [VAW-1:0]             base_addr,
  input  logic [LENW-1:0]            len,
  input  logic                       abort,
  input  logic [INTWIDTH-1:0]        s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [VAW-1:0]             X_wr,
  output logic [INTWIDTH*CORE_N-1:0] X_din,
  output logic                       X_din_valid,
  output logic                       wr_finish,
  output logic                       busy
);

  localparam int unsigned ITERA = KSIZE / CORE_N;
  localparam int unsigned LANEW = (CORE_N > 1) ? $clog2(CORE_N) : 1;
  localparam int unsigned ITERW = (ITERA > 1) ? $clog2(ITERA) : 1;

  state_t state, state_next;

  logic [VAW-1:0]   base_q;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  elem_cnt;
  logic [VAW-1:0]   word_cnt;
  logic [LANEW-1:0] lane_cnt;

  logic [VAW-1:0]   addr_cur;
  logic [VAW-1:0]   addr_after;
  logic             load_start;
  logic             beat;
  logic             last;
  logic             close;
  logic             pad_wr;

  assign addr_cur   = base_q + word_cnt;
  assign addr_after = addr_cur + VAW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_start = 1'b0;
    beat       = 1'b0;
    last       = 1'b0;
    close      = 1'b0;
    pad_wr     = 1'b0;
    s_ready    = 1'b0;
    wr_finish  = 1'b0;
    busy       = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          load_start = 1'b1;
          state_next = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        s_ready = 1'b1;
        beat    = s_valid;
        if (beat) begin
          last  = ((elem_cnt + LENW'(1)) == len_q);
          close = last || (lane_cnt == LANEW'(CORE_N - 1));
          if (last) begin
            state_next = (addr_after[ITERW-1:0] != '0) ? S_PAD : S_DONE;
          end
        end
      end
      S_PAD: begin
        pad_wr = 1'b1;
        if (addr_cur[ITERW-1:0] == ITERW'(ITERA - 1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Entered together with the final registered write (if any); the
        // pulse is held back until that write has been presented.
        wr_finish  = !X_din_valid;
        state_next = X_din_valid ? S_DONE : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (abort) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      len_q       <= '0;
      elem_cnt    <= '0;
      word_cnt    <= '0;
      lane_cnt    <= '0;
      X_wr        <= '0;
      X_din_valid <= 1'b0;
    end else begin
      // Writes decided in an abort cycle are still emitted.
      X_din_valid <= close || pad_wr;
      if (close || pad_wr) begin
        X_wr <= addr_cur;
      end

      if (abort) begin
        elem_cnt <= '0;
        word_cnt <= '0;
        lane_cnt <= '0;
      end else if (load_start) begin
        base_q   <= base_addr;
        len_q    <= len;
        elem_cnt <= '0;
        word_cnt <= '0;
        lane_cnt <= '0;
      end else begin
        if (beat) begin
          elem_cnt <= elem_cnt + LENW'(1);
          lane_cnt <= close ? '0 : lane_cnt + LANEW'(1);
        end
        if (close || pad_wr) begin
          word_cnt <= word_cnt + VAW'(1);
        end
      end
    end
  end

  xram_lane_packer #(
    .INTWIDTH (INTWIDTH),
    .CORE_N   (CORE_N),
    .LANEW    (LANEW)
  ) u_lanes (
    .clk   (clk),
    .rst   (rst),
    .clr   (load_start || abort),
    .beat  (beat),
    .close (close),
    .pad   (pad_wr),
    .lane  (lane_cnt),
    .data  (s_data),
    .word  (X_din)
  );

endmodule
